vga_cfg_sequencer: RTL

Configuration sequencer for the VGA timing block. After a `start` pulse it walks a fixed 8-entry table of timing values (margins, sync pulses, counter maxima) and writes each entry into the VGA configuration port over the `c_valid`/`c_ready` handshake. Between sequences it arbitrates single host writes onto the same port. It sits between the system controller and `VGA`, and is the only master of the VGA `c_*` interface.

---
 rtl/vga_cfg_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vga_cfg_sequencer.sv
// vga_cfg_sequencer: walks a fixed 8-entry VGA timing table onto the c_* config
// port and, between table runs, forwards single host writes onto that port.
module vga_cfg_sequencer #(
    parameter int CONFIG_WIDTH = 4,
    parameter int H_LEFT       = 1,
    parameter int V_LEFT       = 2,
    parameter int H_RIGHT      = 7,
    parameter int V_RIGHT      = 8,
    parameter int H_SYNC       = 1,
    parameter int V_SYNC       = 0,
    parameter int H_MAX        = 10,
    parameter int V_MAX        = 12,
    parameter int TIMEOUT      = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    host_valid,
    input  logic [CONFIG_WIDTH-1:0] host_addr,
    input  logic [CONFIG_WIDTH-1:0] host_data,
    output logic                    host_ready,
    output logic                    c_valid,
    output logic [CONFIG_WIDTH-1:0] c_addr,
    output logic [CONFIG_WIDTH-1:0] c_data,
    input  logic                    c_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    typedef enum logic [2:0] {S_IDLE, S_SEQ, S_HOST, S_DONE, S_ERR} state_t;

    state_t                  state_q, ret_q;
    logic [2:0]              idx_q, idx_d;
    logic [7:0]              stall_q, stall_d;
    logic                    c_valid_q, busy_q, done_q, error_q;
    logic [CONFIG_WIDTH-1:0] c_addr_q, c_data_q;
    logic                    xfer, timed_out, quiet;

    // Timing table, indexed by config address.
    function automatic logic [CONFIG_WIDTH-1:0] tbl(input logic [2:0] i);
        case (i)
            3'd0:    tbl = CONFIG_WIDTH'(H_LEFT);
            3'd1:    tbl = CONFIG_WIDTH'(V_LEFT);
            3'd2:    tbl = CONFIG_WIDTH'(H_RIGHT);
            3'd3:    tbl = CONFIG_WIDTH'(V_RIGHT);
            3'd4:    tbl = CONFIG_WIDTH'(H_SYNC);
            3'd5:    tbl = CONFIG_WIDTH'(V_SYNC);
            3'd6:    tbl = CONFIG_WIDTH'(H_MAX);
            default: tbl = CONFIG_WIDTH'(V_MAX);
        endcase
    endfunction

    // Handshake, stall bookkeeping and the host accept window.
    always_comb begin
        xfer       = c_valid_q & c_ready;
        timed_out  = (TIMEOUT != 0) && (stall_q == 8'(TIMEOUT));
        idx_d      = idx_q + 3'd1;
        // Saturate so a disabled timeout never wraps the counter.
        stall_d    = (c_valid_q && !c_ready && stall_q != 8'hFF) ? stall_q + 8'd1 : stall_q;
        quiet      = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
        host_ready = quiet & ~start;
    end

    // Sequencer FSM with registered port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ret_q     <= S_IDLE;
            idx_q     <= 3'd0;
            stall_q   <= 8'd0;
            c_valid_q <= 1'b0;
            c_addr_q  <= '0;
            c_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q   <= S_SEQ;
                        idx_q     <= 3'd0;
                        stall_q   <= 8'd0;
                        c_valid_q <= 1'b1;
                        c_addr_q  <= '0;
                        c_data_q  <= tbl(3'd0);
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                    end else if (host_valid) begin
                        // done/error levels survive a host write.
                        ret_q     <= state_q;
                        state_q   <= S_HOST;
                        stall_q   <= 8'd0;
                        c_valid_q <= 1'b1;
                        c_addr_q  <= host_addr;
                        c_data_q  <= host_data;
                        busy_q    <= 1'b1;
                    end
                end
                S_SEQ: begin
                    if (xfer) begin
                        stall_q <= 8'd0;
                        if (idx_q == 3'd7) begin
                            state_q   <= S_DONE;
                            c_valid_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            // Next entry goes out back-to-back, c_valid stays high.
                            idx_q    <= idx_d;
                            c_addr_q <= CONFIG_WIDTH'(idx_d);
                            c_data_q <= tbl(idx_d);
                        end
                    end else if (timed_out) begin
                        state_q   <= S_ERR;
                        c_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                        error_q   <= 1'b1;
                    end else begin
                        stall_q <= stall_d;
                    end
                end
                S_HOST: begin
                    if (xfer) begin
                        state_q   <= ret_q;
                        stall_q   <= 8'd0;
                        c_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (timed_out) begin
                        state_q   <= S_ERR;
                        c_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                        error_q   <= 1'b1;
                    end else begin
                        stall_q <= stall_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign c_valid = c_valid_q;
    assign c_addr  = c_addr_q;
    assign c_data  = c_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule
